fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'hE1A0_0000 (MOV r0,r0), the bubble instruction.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port PCSrc  input  1  branch/redirect taken.
REQ-006 SHALL have port BranchTarget  input  32  redirect address.
REQ-007 SHALL have port StallF  input  1  hazard stall of the fetch stage and the decode register.
REQ-008 SHALL have port FlushD  input  1  load a bubble into the decode register.
REQ-009 SHALL have port imem_req  output  1  instruction-memory request.
REQ-010 SHALL have port imem_addr  output  32  fetch address, always equal to PCF.
REQ-011 SHALL have port imem_ready  input  1  memory has valid data this cycle.
REQ-012 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-013 SHALL have port InstrD  output  32  registered instruction for the Decode stage.
REQ-014 SHALL have port PCPlus4D  output  32  registered PC+4 for Decode, which forms PCPlus8 from it.
REQ-015 SHALL have port ValidD  output  1  InstrD is a real instruction, not a bubble.

Function
REQ-016 SHALL implement FSM states FETCH (imem_req=1) and HOLD (imem_req=0, fetched word parked in a one-entry buffer).
REQ-017 A fetch SHALL complete in any FETCH cycle with imem_ready=1; imem_addr SHALL stay stable until completion unless PCSrc=1.
REQ-018 On completion with StallF=0: InstrD<=imem_rdata, PCPlus4D<=PCF+4, ValidD<=1, PCF<=PCF+4, stay in FETCH; decode-register latency is one cycle from completion.
REQ-019 On completion with StallF=1: buffer<=imem_rdata, PCF unchanged, decode register unchanged, go to HOLD.
REQ-020 In HOLD with StallF=0: decode register loads buffer, PCPlus4D<=PCF+4, ValidD<=1, PCF<=PCF+4, go to FETCH; with StallF=1, stay in HOLD with all state held.
REQ-021 In FETCH without completion: StallF=0 loads a bubble (InstrD=NOP_INSTR, PCPlus4D=PCF+4, ValidD=0); StallF=1 holds the decode register.
REQ-022 PCSrc=1 SHALL take priority over all other events: PCF<={BranchTarget[31:2],2'b00}, a same-cycle completion and any HOLD buffer are discarded, next state is FETCH.
REQ-023 FlushD=1 SHALL load a bubble into the decode register, overriding StallF and any completion or HOLD transfer for the decode register only; PC and FSM follow REQ-018..022.
REQ-024 PC arithmetic SHALL be modulo 2^32: PCF=32'hFFFF_FFFC increments to 32'h0000_0000.
REQ-025 PCF[1:0] SHALL always be 2'b00.

Reset
REQ-026 When rst_n=0 at a rising edge: PCF<=RESET_PC, state<=FETCH, buffer<=NOP_INSTR, InstrD<=NOP_INSTR, PCPlus4D<=0, ValidD<=0; reset overrides all inputs, including mid-fetch or in HOLD.
REQ-027 imem_req SHALL be 1 in the first cycle after rst_n deasserts.

Structure
REQ-028 NOP_INSTR and the FSM state encoding SHALL reside in the shared pipeline package used by all stages.
REQ-029 SHALL contain one natural sub-module, ifid_reg (decode register with enable, flush and reset); the PC register and FSM stay in fetch_stage.

Verification
REQ-030 Reset to RESET_PC=0 with imem_ready held at 1 -> imem_addr 0,4,8 on consecutive cycles; InstrD follows rdata one cycle later; PCPlus4D 4,8,12.
REQ-031 imem_ready=0 for 3 cycles at PCF=8 -> imem_addr stays 8; three bubbles with ValidD=0 and InstrD=E1A00000.
REQ-032 Completion at PCF=0x10 with StallF=1 for 2 cycles -> HOLD, imem_req=0, InstrD unchanged; when StallF drops, InstrD=buffered word, PCPlus4D=0x14, next imem_addr 0x14.
REQ-033 PCSrc=1, FlushD=1, BranchTarget=0x103, during completion -> PCF=0x100, same-cycle word dropped, ValidD=0 next cycle.
REQ-034 Initial PCF=FFFFFFFC, then completion -> PCPlus4D=0, next imem_addr=0.
REQ-035 rst_n=0 while in HOLD -> next cycle state FETCH, imem_addr=RESET_PC, ValidD=0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions: bubble encoding, fetch FSM states and PC helpers.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcplus4;
    logic        valid;
  } ifid_t;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] pc_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// Fetch/Decode pipeline register: synchronous reset, flush to a bubble, load enable.
module ifid_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        flush,
  input  ifid_t       d,
  output logic [31:0] instrd,
  output logic [31:0] pcplus4d,
  output logic        validd
);

  ifid_t q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q.instr   <= NOP_INSTR;
      q.pcplus4 <= '0;
      q.valid   <= 1'b0;
    end else if (flush) begin
      // Flush keeps the PC+4 of the slot so Decode still sees a coherent PC.
      q.instr   <= NOP_INSTR;
      q.pcplus4 <= d.pcplus4;
      q.valid   <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end

  assign instrd   = q.instr;
  assign pcplus4d = q.pcplus4;
  assign validd   = q.valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, memory handshake FSM with a one-word
// park buffer for stalls, feeding the IF/ID register.
//
// state | meaning
// ------+-----------------------------------------------------------------
// FETCH | imem_req high, waiting for imem_ready at imem_addr = PCF
// HOLD  | word already fetched but Decode stalled; word parked in buffer
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCSrc,
  input  logic [31:0] BranchTarget,
  input  logic        StallF,
  input  logic        FlushD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  fetch_state_e state, state_nxt;
  logic [31:0]  pcf;
  logic [31:0]  buffer;
  logic [31:0]  pcf_plus4;
  logic         complete;
  logic         hold_xfer;
  logic         advance;
  ifid_t        ifid_d;

  assign pcf_plus4 = pc_inc(pcf);

  // A redirect squashes both a same-cycle completion and a parked word.
  assign complete  = (state == FETCH) && imem_ready && !PCSrc;
  assign hold_xfer = (state == HOLD) && !StallF && !PCSrc;
  assign advance   = (complete && !StallF) || hold_xfer;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (PCSrc) begin
      state_nxt = FETCH;
    end else begin
      case (state)
        FETCH:   if (imem_ready && StallF) state_nxt = HOLD;
        HOLD:    if (!StallF) state_nxt = FETCH;
        default: state_nxt = FETCH;
      endcase
    end
  end

  always_comb begin
    imem_req = (state == FETCH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcf    <= pc_align(RESET_PC);
      buffer <= NOP_INSTR;
    end else begin
      if (PCSrc) begin
        pcf    <= pc_align(BranchTarget);
        buffer <= NOP_INSTR;
      end else begin
        if (advance) pcf <= pcf_plus4;
        if (complete && StallF) buffer <= imem_rdata;
      end
    end
  end

  assign imem_addr = pcf;

  // Without a completion or transfer, an unstalled decode register takes a bubble.
  always_comb begin
    ifid_d.pcplus4 = pcf_plus4;
    ifid_d.instr   = NOP_INSTR;
    ifid_d.valid   = 1'b0;
    if (complete) begin
      ifid_d.instr = imem_rdata;
      ifid_d.valid = 1'b1;
    end else if (hold_xfer) begin
      ifid_d.instr = buffer;
      ifid_d.valid = 1'b1;
    end
  end

  ifid_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_ifid_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (!StallF),
    .flush    (FlushD),
    .d        (ifid_d),
    .instrd   (InstrD),
    .pcplus4d (PCPlus4D),
    .validd   (ValidD)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table then random
// traffic compared against a behavioural model of the fetch rules.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'hE1A0_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PCSrc;
  logic [31:0] BranchTarget;
  logic        StallF;
  logic        FlushD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD;
  logic [31:0] PCPlus4D;
  logic        ValidD;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .PCSrc(PCSrc), .BranchTarget(BranchTarget),
    .StallF(StallF), .FlushD(FlushD), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .InstrD(InstrD),
    .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  // Reference model: fetch pointer, a "word parked" flag and the decode slot.
  logic [31:0] m_pc, m_park, m_instr, m_pc4;
  logic        m_parked, m_valid;

  task automatic model_edge();
    logic [31:0] pc0;
    logic got_word, from_park;
    pc0 = m_pc;
    if (!rst_n) begin
      m_pc = 32'h0; m_parked = 0; m_park = NOP;
      m_instr = NOP; m_pc4 = 0; m_valid = 0;
      return;
    end
    got_word  = !m_parked && imem_ready && !PCSrc;
    from_park = m_parked && !StallF && !PCSrc;
    if (FlushD) begin
      m_instr = NOP; m_pc4 = pc0 + 4; m_valid = 0;
    end else if (!StallF) begin
      m_pc4 = pc0 + 4;
      if (got_word)       begin m_instr = imem_rdata; m_valid = 1; end
      else if (from_park) begin m_instr = m_park;     m_valid = 1; end
      else                begin m_instr = NOP;        m_valid = 0; end
    end
    if (PCSrc) begin
      m_pc = {BranchTarget[31:2], 2'b00}; m_parked = 0; m_park = NOP;
    end else if (got_word && StallF) begin
      m_parked = 1; m_park = imem_rdata;
    end else if ((got_word && !StallF) || from_park) begin
      m_pc = pc0 + 4; m_parked = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst_n, pcsrc, stall, flush, ready;
    logic [31:0] bt, rdata;
    logic        e_req;
    logic [31:0] e_addr, e_instr, e_pc4;
    logic        e_valid;
  } vec_t;

  vec_t v[$];

  function automatic vec_t mk(logic r, logic ps, logic [31:0] bt, logic st, logic fl,
                              logic rdy, logic [31:0] rd, logic eq, logic [31:0] ea,
                              logic [31:0] ei, logic [31:0] ep, logic ev);
    vec_t x;
    x.rst_n = r; x.pcsrc = ps; x.bt = bt; x.stall = st; x.flush = fl;
    x.ready = rdy; x.rdata = rd; x.e_req = eq; x.e_addr = ea;
    x.e_instr = ei; x.e_pc4 = ep; x.e_valid = ev;
    return x;
  endfunction

  initial begin
    rst_n = 0; PCSrc = 0; BranchTarget = 0; StallF = 0; FlushD = 0;
    imem_ready = 0; imem_rdata = 0;

    //        rst ps bt            st fl rdy rdata          req addr          instr        pc4           v
    v.push_back(mk(0, 0, 32'h0,        0, 0, 1, 32'h0,        1, 32'h0,        NOP,         32'h0,        0));
    v.push_back(mk(0, 0, 32'h0,        0, 0, 1, 32'h0,        1, 32'h0,        NOP,         32'h0,        0));
    v.push_back(mk(1, 0, 32'h0,        0, 0, 1, 32'hA000_0000,1, 32'h4,        32'hA000_0000,32'h4,       1));
    v.push_back(mk(1, 0, 32'h0,        0, 0, 1, 32'hA000_0001,1, 32'h8,        32'hA000_0001,32'h8,       1));
    v.push_back(mk(1, 0, 32'h0,        0, 0, 0, 32'h1111_1111,1, 32'h8,        NOP,         32'hC,        0));
    v.push_back(mk(1, 0, 32'h0,        0, 0, 0, 32'h2222_2222,1, 32'h8,        NOP,         32'hC,        0));
    v.push_back(mk(1, 0, 32'h0,        0, 0, 0, 32'h3333_3333,1, 32'h8,        NOP,         32'hC,        0));
    v.push_back(mk(1, 0, 32'h0,        0, 0, 1, 32'hA000_0002,1, 32'hC,        32'hA000_0002,32'hC,       1));
    v.push_back(mk(1, 0, 32'h0,        0, 0, 1, 32'hA000_0003,1, 32'h10,       32'hA000_0003,32'h10,      1));
    v.push_back(mk(1, 0, 32'h0,        1, 0, 1, 32'hB000_0000,0, 32'h10,       32'hA000_0003,32'h10,      1));
    v.push_back(mk(1, 0, 32'h0,        1, 0, 1, 32'hDEAD_BEEF,0, 32'h10,       32'hA000_0003,32'h10,      1));
    v.push_back(mk(1, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h14,       32'hB000_0000,32'h14,      1));
    v.push_back(mk(1, 1, 32'h103,      0, 1, 1, 32'hC000_0000,1, 32'h100,      NOP,         32'h18,       0));
    v.push_back(mk(1, 0, 32'h0,        0, 0, 1, 32'hC000_0001,1, 32'h104,      32'hC000_0001,32'h104,     1));
    v.push_back(mk(1, 1, 32'hFFFF_FFFF,0, 0, 0, 32'h0,        1, 32'hFFFF_FFFC,NOP,         32'h108,      0));
    v.push_back(mk(1, 0, 32'h0,        0, 0, 1, 32'hD000_0000,1, 32'h0,        32'hD000_0000,32'h0,       1));
    v.push_back(mk(1, 0, 32'h0,        0, 0, 1, 32'hD000_0001,1, 32'h4,        32'hD000_0001,32'h4,       1));
    v.push_back(mk(1, 0, 32'h0,        1, 0, 1, 32'hE000_0000,0, 32'h4,        32'hD000_0001,32'h4,       1));
    v.push_back(mk(1, 0, 32'h0,        1, 1, 1, 32'h0,        0, 32'h4,        NOP,         32'h8,        0));
    v.push_back(mk(0, 0, 32'h0,        1, 0, 1, 32'h0,        1, 32'h0,        NOP,         32'h0,        0));
    v.push_back(mk(1, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0,        NOP,         32'h4,        0));

    for (int i = 0; i < v.size(); i++) begin
      rst_n = v[i].rst_n; PCSrc = v[i].pcsrc; BranchTarget = v[i].bt;
      StallF = v[i].stall; FlushD = v[i].flush; imem_ready = v[i].ready;
      imem_rdata = v[i].rdata;
      step();
      chk($sformatf("vec%0d.req", i),   {31'b0, imem_req}, {31'b0, v[i].e_req});
      chk($sformatf("vec%0d.addr", i),  imem_addr, v[i].e_addr);
      chk($sformatf("vec%0d.instr", i), InstrD, v[i].e_instr);
      chk($sformatf("vec%0d.pc4", i),   PCPlus4D, v[i].e_pc4);
      chk($sformatf("vec%0d.valid", i), {31'b0, ValidD}, {31'b0, v[i].e_valid});
    end

    for (int i = 0; i < 600; i++) begin
      rst_n        = ($urandom_range(0, 59) != 0);
      PCSrc        = ($urandom_range(0, 7) == 0);
      BranchTarget = $urandom;
      StallF       = ($urandom_range(0, 3) == 0);
      FlushD       = ($urandom_range(0, 7) == 0);
      imem_ready   = $urandom_range(0, 1) == 1;
      imem_rdata   = $urandom;
      step();
      chk("rnd.req",   {31'b0, imem_req}, {31'b0, !m_parked});
      chk("rnd.addr",  imem_addr, m_pc);
      chk("rnd.instr", InstrD, m_instr);
      chk("rnd.pc4",   PCPlus4D, m_pc4);
      chk("rnd.valid", {31'b0, ValidD}, {31'b0, m_valid});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
